// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART Receiver / host consumer side and the receive
// controller. The controller takes the slave view; the environment that
// drives the Receiver outputs and consumes bytes takes the master view.
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Receiver side (level-held per frame)
    logic                 Rx_Data_Rdy;
    logic [DATA_BITS-1:0] Rx_Data;
    logic [2:0]           Rx_Error;
    logic                 Rx_RTS;
    logic                 RTS_Out;

    // Consumer side
    logic                 Out_Valid;
    logic [DATA_BITS-1:0] Out_Data;
    logic                 Out_Ready;
    logic [CW-1:0]        Fifo_Count;

    // Statistics
    logic [CNT_W-1:0]     Overrun_Cnt;
    logic [CNT_W-1:0]     Parity_Cnt;
    logic [CNT_W-1:0]     Frame_Cnt;
    logic [CNT_W-1:0]     Break_Cnt;
    logic                 Err_Clr;

    modport slave (
        input  Rx_Data_Rdy, Rx_Data, Rx_Error, Rx_RTS, Out_Ready, Err_Clr,
        output RTS_Out, Out_Valid, Out_Data, Fifo_Count,
               Overrun_Cnt, Parity_Cnt, Frame_Cnt, Break_Cnt
    );

    modport master (
        output Rx_Data_Rdy, Rx_Data, Rx_Error, Rx_RTS, Out_Ready, Err_Clr,
        input  RTS_Out, Out_Valid, Out_Data, Fifo_Count,
               Overrun_Cnt, Parity_Cnt, Frame_Cnt, Break_Cnt
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: detects each completed Receiver frame once,
// buffers good bytes in a first-word-fall-through FIFO, keeps saturating
// error statistics and throttles the far end via RTS with hysteresis.
module uart_rx_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int RTS_HIGH_WM = 12,
    parameter int RTS_LOW_WM  = 8,
    parameter int CNT_W       = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    uart_rx_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] HIGH_C  = CW'(RTS_HIGH_WM);
    localparam logic [CW-1:0] LOW_C   = CW'(RTS_LOW_WM);

    // Counter slots in the packed statistics array
    localparam int C_BREAK   = 0;
    localparam int C_PARITY  = 1;
    localparam int C_FRAME   = 2;
    localparam int C_OVERRUN = 3;

    typedef enum logic {
        IDLE,
        WAIT_RELEASE
    } state_t;

    state_t state_q, state_d;
    logic   frame_active;
    logic   capture;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 full, empty;
    logic                 push_req, pop, wr_en, overrun;
    logic [2:0]           err_evt;

    logic                 hold_q, hold_d;
    logic                 rts_q;

    logic [3:0]             inc;
    logic [3:0][CNT_W-1:0]  cnt_q;

    // The Receiver holds its outputs for the whole done state, so a frame
    // is "active" while either the data strobe or any error bit is up.
    assign frame_active = bus.Rx_Data_Rdy | (|bus.Rx_Error);

    // Frame monitor state register
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Frame monitor: one capture on entry to a frame, then wait for release
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_active) begin
                    capture = 1'b1;
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!frame_active) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A good byte wins over any error bits held in the same frame
    assign push_req = capture & bus.Rx_Data_Rdy;
    assign err_evt  = (capture & ~bus.Rx_Data_Rdy) ? bus.Rx_Error : 3'b000;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign pop   = ~empty & bus.Out_Ready;

    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign wr_en   = push_req & (~full | pop);
    assign overrun = push_req & full & ~pop;

    assign count_d = count_q + CW'(wr_en) - CW'(pop);

    // FIFO storage; no reset needed since reads are gated by occupancy
    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_ptr_q] <= bus.Rx_Data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Hysteresis decision on the post-update occupancy
    always_comb begin
        hold_d = hold_q;
        if (count_d >= HIGH_C)     hold_d = 1'b1;
        else if (count_d <= LOW_C) hold_d = 1'b0;
    end

    // Hold flag and registered RTS toward the far-end transmitter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hold_q <= 1'b0;
            rts_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rts_q  <= bus.Rx_RTS & ~hold_d;
        end
    end

    assign inc[C_BREAK]   = err_evt[0];
    assign inc[C_PARITY]  = err_evt[1];
    assign inc[C_FRAME]   = err_evt[2];
    assign inc[C_OVERRUN] = overrun;

    // Saturating statistics; a clear beats a same-cycle increment
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (Rst || bus.Err_Clr)
                cnt_q[i] <= '0;
            else if (inc[i] && (cnt_q[i] != '1))
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
    end

    assign bus.RTS_Out     = rts_q;
    assign bus.Out_Valid   = ~empty;
    assign bus.Out_Data    = empty ? '0 : mem[rd_ptr_q];
    assign bus.Fifo_Count  = count_q;
    assign bus.Break_Cnt   = cnt_q[C_BREAK];
    assign bus.Parity_Cnt  = cnt_q[C_PARITY];
    assign bus.Frame_Cnt   = cnt_q[C_FRAME];
    assign bus.Overrun_Cnt = cnt_q[C_OVERRUN];
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue scoreboard for FIFO data/occupancy, a
// vector table for error statistics, hand sequences for the corner cases.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 16;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    uart_rx_ctrl_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .CNT_W(8)) bus ();

    uart_rx_ctrl #(
        .DATA_BITS(8), .FIFO_DEPTH(DEPTH), .RTS_HIGH_WM(12),
        .RTS_LOW_WM(8), .CNT_W(8)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sb[$];
    logic       push_pend = 1'b0;
    logic [7:0] push_byte = 8'h00;
    int         exp_ovr   = 0;

    typedef struct {
        logic [2:0] err;
        logic       clr;
        int         hold;
        logic [7:0] b;
        logic [7:0] p;
        logic [7:0] f;
    } evec_t;

    evec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check head against the model before the edge, apply the
    // model's pop/push, then check occupancy after the edge.
    task automatic tick();
        logic do_pop;
        do_pop = (sb.size() != 0) && bus.Out_Ready;
        chk("out_valid", bus.Out_Valid, 32'(sb.size() != 0));
        if (sb.size() == 0) chk("empty_data", bus.Out_Data, 0);
        if (do_pop) begin
            chk("pop_data", bus.Out_Data, sb[0]);
            sb.delete(0);
        end
        if (push_pend) begin
            if (sb.size() < DEPTH) sb.push_back(push_byte);
            else exp_ovr++;
            push_pend = 1'b0;
        end
        @(posedge Clk); #1;
        chk("fifo_count", bus.Fifo_Count, sb.size());
    endtask

    task automatic send_byte(input logic [7:0] d, input int hold, input logic rdy_first);
        bus.Rx_Data_Rdy = 1'b1;
        bus.Rx_Data     = d;
        bus.Out_Ready   = rdy_first;
        push_pend = 1'b1;
        push_byte = d;
        tick();
        bus.Out_Ready = 1'b0;
        repeat (hold - 1) tick();
        bus.Rx_Data_Rdy = 1'b0;
        bus.Rx_Data     = 8'h00;
        tick();
    endtask

    task automatic send_err(input logic [2:0] e, input int hold, input logic clr_first);
        bus.Rx_Error = e;
        bus.Err_Clr  = clr_first;
        tick();
        bus.Err_Clr = 1'b0;
        repeat (hold - 1) tick();
        bus.Rx_Error = 3'b000;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rts"},     bus.RTS_Out, 0);
        chk({tag, "_valid"},   bus.Out_Valid, 0);
        chk({tag, "_data"},    bus.Out_Data, 0);
        chk({tag, "_count"},   bus.Fifo_Count, 0);
        chk({tag, "_overrun"}, bus.Overrun_Cnt, 0);
        chk({tag, "_parity"},  bus.Parity_Cnt, 0);
        chk({tag, "_frame"},   bus.Frame_Cnt, 0);
        chk({tag, "_break"},   bus.Break_Cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{err: 3'b110, clr: 1'b0, hold: 4, b: 8'd0, p: 8'd1, f: 8'd1};
        vecs[1] = '{err: 3'b001, clr: 1'b0, hold: 2, b: 8'd1, p: 8'd1, f: 8'd1};
        vecs[2] = '{err: 3'b111, clr: 1'b0, hold: 3, b: 8'd2, p: 8'd2, f: 8'd2};
        vecs[3] = '{err: 3'b010, clr: 1'b1, hold: 2, b: 8'd0, p: 8'd0, f: 8'd0};
        vecs[4] = '{err: 3'b100, clr: 1'b0, hold: 1, b: 8'd0, p: 8'd0, f: 8'd1};
        vecs[5] = '{err: 3'b000, clr: 1'b1, hold: 1, b: 8'd0, p: 8'd0, f: 8'd0};

        bus.Rx_Data_Rdy = 1'b0;
        bus.Rx_Data     = 8'h00;
        bus.Rx_Error    = 3'b000;
        bus.Rx_RTS      = 1'b1;
        bus.Out_Ready   = 1'b0;
        bus.Err_Clr     = 1'b0;

        // Reset state
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk_all_zero("reset");
        Rst = 1'b0;
        tick();
        chk("rts_idle", bus.RTS_Out, 1);

        // Single frame held 3 cycles -> one push, then pop
        send_byte(8'hA5, 3, 1'b0);
        chk("single_count", bus.Fifo_Count, 1);
        chk("single_ovr", bus.Overrun_Cnt, 0);
        bus.Out_Ready = 1'b1;
        tick();
        bus.Out_Ready = 1'b0;
        chk("single_drained", bus.Out_Valid, 0);

        // Error statistics vector table
        for (int i = 0; i < 6; i++) begin
            send_err(vecs[i].err, vecs[i].hold, vecs[i].clr);
            chk($sformatf("vec%0d_break", i),  bus.Break_Cnt,  vecs[i].b);
            chk($sformatf("vec%0d_parity", i), bus.Parity_Cnt, vecs[i].p);
            chk($sformatf("vec%0d_frame", i),  bus.Frame_Cnt,  vecs[i].f);
        end

        // Saturation: 260 break frames stop at 255
        for (int i = 0; i < 260; i++) send_err(3'b001, 1, 1'b0);
        chk("sat_break", bus.Break_Cnt, 255);
        chk("sat_parity", bus.Parity_Cnt, 0);
        send_err(3'b000, 1, 1'b1);
        chk("sat_clr", bus.Break_Cnt, 0);

        // Overrun: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_byte(8'(i), 2, 1'b0);
        chk("ovr_count", bus.Fifo_Count, 16);
        chk("ovr_cnt", bus.Overrun_Cnt, 1);
        chk("ovr_model", bus.Overrun_Cnt, exp_ovr);
        chk("ovr_rts", bus.RTS_Out, 0);
        bus.Out_Ready = 1'b1;
        repeat (16) tick();
        bus.Out_Ready = 1'b0;
        chk("ovr_drained", bus.Fifo_Count, 0);

        // RTS hysteresis
        for (int i = 0; i < 11; i++) send_byte(8'h40 + 8'(i), 1, 1'b0);
        chk("rts_at11", bus.RTS_Out, 1);
        send_byte(8'h4B, 1, 1'b0);
        chk("rts_at12", bus.RTS_Out, 0);
        bus.Out_Ready = 1'b1;
        tick();
        tick();
        tick();
        chk("rts_at9", bus.RTS_Out, 0);
        tick();
        chk("rts_at8", bus.RTS_Out, 1);
        bus.Out_Ready = 1'b0;
        bus.Rx_RTS = 1'b0;
        tick();
        chk("rts_rx_low", bus.RTS_Out, 0);
        bus.Rx_RTS = 1'b1;
        tick();
        chk("rts_rx_high", bus.RTS_Out, 1);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) send_byte(8'h80 + 8'(i), 1, 1'b0);
        chk("full_count", bus.Fifo_Count, 16);
        send_byte(8'hEE, 2, 1'b1);
        chk("simul_count", bus.Fifo_Count, 16);
        chk("simul_ovr", bus.Overrun_Cnt, 1);
        bus.Out_Ready = 1'b1;
        repeat (16) tick();
        bus.Out_Ready = 1'b0;
        chk("simul_drained", bus.Fifo_Count, 0);
        chk("sb_empty", sb.size(), 0);

        // Reset mid-operation with a frame held across the reset
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1, 1'b0);
        send_err(3'b100, 1, 1'b0);
        chk("pre_rst_frame", bus.Frame_Cnt, 1);
        bus.Rx_Data_Rdy = 1'b1;
        bus.Rx_Data     = 8'h3C;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk_all_zero("midrst");
        sb.delete();
        exp_ovr = 0;
        Rst = 1'b0;
        push_pend = 1'b1;
        push_byte = 8'h3C;
        tick();
        tick();
        bus.Rx_Data_Rdy = 1'b0;
        bus.Rx_Data     = 8'h00;
        tick();
        chk("post_rst_count", bus.Fifo_Count, 1);
        chk("post_rst_frame", bus.Frame_Cnt, 0);
        bus.Out_Ready = 1'b1;
        tick();
        bus.Out_Ready = 1'b0;
        chk("post_rst_drained", bus.Out_Valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
